// File: rtl/batalla_pkg.sv
// Shared definitions for the battleship game: cell encodings, shot results,
// board geometry and the resolver state encoding.
package batalla_pkg;

    localparam int BOARD_N = 5;

    typedef enum logic [1:0] {
        AGUA          = 2'b00,
        BARCO         = 2'b01,
        TIRO_FALLADO  = 2'b10,
        TIRO_ACERTADO = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        MISS    = 2'b00,
        HIT     = 2'b01,
        REPEAT  = 2'b10,
        INVALID = 2'b11
    } shot_result_t;

    // Board indexed as board[row][col].
    typedef cell_t [BOARD_N-1:0][BOARD_N-1:0] board_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_READY  = 3'd2,
        S_CHECK  = 3'd3,
        S_WRITE  = 3'd4,
        S_REPORT = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Value a shot leaves behind in a cell; already-shot cells are unchanged.
    function automatic cell_t mark_cell(input cell_t c);
        case (c)
            AGUA:    mark_cell = TIRO_FALLADO;
            BARCO:   mark_cell = TIRO_ACERTADO;
            default: mark_cell = c;
        endcase
    endfunction

endpackage

// File: rtl/shot_resolver_if.sv
// Shot request / board write / result handshake between the turn logic
// (master) and the shot resolver (slave).
interface shot_resolver_if;
    import batalla_pkg::*;

    logic         shot_valid;
    logic [2:0]   shot_row;
    logic [2:0]   shot_col;
    logic         shot_ready;
    logic         wr_en;
    logic [2:0]   wr_row;
    logic [2:0]   wr_col;
    cell_t        wr_data;
    logic         result_valid;
    shot_result_t result_code;

    modport master (
        output shot_valid, shot_row, shot_col,
        input  shot_ready, wr_en, wr_row, wr_col, wr_data, result_valid, result_code
    );

    modport slave (
        input  shot_valid, shot_row, shot_col,
        output shot_ready, wr_en, wr_row, wr_col, wr_data, result_valid, result_code
    );

endinterface

// File: rtl/shot_resolver.sv
// Shot resolver: scans the target board for ship cells, then accepts one shot
// at a time, classifies it, writes the marked cell back and reports the result.
// Every shot takes the same CHECK/WRITE/REPORT path so latency is fixed.
module shot_resolver
    import batalla_pkg::*;
#(
    parameter int N  = BOARD_N,
    parameter int CW = $clog2(N*N+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  cell_t [N-1:0][N-1:0]    board,
    shot_resolver_if.slave          sif,
    output logic [CW-1:0]           ships_left,
    output logic                    game_over,
    output logic                    busy
);

    localparam logic [2:0] DIM_L    = 3'(N);
    localparam logic [2:0] LAST_IDX = 3'(N-1);

    state_t       r_state;
    logic [2:0]   r_row;
    logic [2:0]   r_col;
    logic [2:0]   r_scan_row;
    logic [2:0]   r_scan_col;
    logic [CW-1:0] r_ships;
    logic         r_shot_ready;
    logic         r_busy;
    logic         r_game_over;
    logic         r_wr_en;
    logic [2:0]   r_wr_row;
    logic [2:0]   r_wr_col;
    cell_t        r_wr_data;
    logic         r_result_valid;
    shot_result_t r_result_code;

    logic          w_in_range;
    logic [2:0]    w_rd_row;
    logic [2:0]    w_rd_col;
    cell_t         w_shot_cell;
    cell_t         w_scan_cell;
    logic [CW-1:0] w_scan_count;
    logic          w_scan_last;
    logic          w_start_scan;

    // Shot cell lookup; the index is clamped so an off-board shot never reads
    // past the array (its cell value is unused in that case).
    assign w_in_range   = (r_row < DIM_L) && (r_col < DIM_L);
    assign w_rd_row     = w_in_range ? r_row : 3'd0;
    assign w_rd_col     = w_in_range ? r_col : 3'd0;
    assign w_shot_cell  = board[w_rd_row][w_rd_col];

    assign w_scan_cell  = board[r_scan_row][r_scan_col];
    assign w_scan_count = r_ships + CW'(w_scan_cell == BARCO);
    assign w_scan_last  = (r_scan_row == LAST_IDX) && (r_scan_col == LAST_IDX);

    // start only (re)arms from the idle, waiting and finished states.
    assign w_start_scan = start &&
                          ((r_state == S_IDLE) || (r_state == S_READY) || (r_state == S_DONE));

    // Main FSM with registered outputs and the ship counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_row          <= 3'd0;
            r_col          <= 3'd0;
            r_scan_row     <= 3'd0;
            r_scan_col     <= 3'd0;
            r_ships        <= '0;
            r_shot_ready   <= 1'b0;
            r_busy         <= 1'b0;
            r_game_over    <= 1'b0;
            r_wr_en        <= 1'b0;
            r_wr_row       <= 3'd0;
            r_wr_col       <= 3'd0;
            r_wr_data      <= AGUA;
            r_result_valid <= 1'b0;
            r_result_code  <= MISS;
        end else begin
            r_wr_en        <= 1'b0;
            r_result_valid <= 1'b0;

            if (w_start_scan) begin
                r_state      <= S_SCAN;
                r_scan_row   <= 3'd0;
                r_scan_col   <= 3'd0;
                r_ships      <= '0;
                r_busy       <= 1'b1;
                r_game_over  <= 1'b0;
                r_shot_ready <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end

                    S_SCAN: begin
                        r_ships <= w_scan_count;
                        if (r_scan_col == LAST_IDX) begin
                            r_scan_col <= 3'd0;
                            r_scan_row <= r_scan_row + 3'd1;
                        end else begin
                            r_scan_col <= r_scan_col + 3'd1;
                        end
                        if (w_scan_last) begin
                            r_busy <= 1'b0;
                            if (w_scan_count == '0) begin
                                r_state     <= S_DONE;
                                r_game_over <= 1'b1;
                            end else begin
                                r_state      <= S_READY;
                                r_shot_ready <= 1'b1;
                            end
                        end
                    end

                    S_READY: begin
                        if (sif.shot_valid) begin
                            r_row        <= sif.shot_row;
                            r_col        <= sif.shot_col;
                            r_state      <= S_CHECK;
                            r_shot_ready <= 1'b0;
                            r_busy       <= 1'b1;
                        end
                    end

                    S_CHECK: begin
                        r_state <= S_WRITE;
                        if (!w_in_range) begin
                            r_result_code <= INVALID;
                        end else begin
                            case (w_shot_cell)
                                AGUA: begin
                                    r_result_code <= MISS;
                                    r_wr_en       <= 1'b1;
                                    r_wr_row      <= r_row;
                                    r_wr_col      <= r_col;
                                    r_wr_data     <= mark_cell(w_shot_cell);
                                end
                                BARCO: begin
                                    r_result_code <= HIT;
                                    r_wr_en       <= 1'b1;
                                    r_wr_row      <= r_row;
                                    r_wr_col      <= r_col;
                                    r_wr_data     <= mark_cell(w_shot_cell);
                                    if (r_ships != '0) begin
                                        r_ships <= r_ships - CW'(1);
                                    end
                                end
                                default: begin
                                    r_result_code <= REPEAT;
                                end
                            endcase
                        end
                    end

                    S_WRITE: begin
                        r_state        <= S_REPORT;
                        r_result_valid <= 1'b1;
                    end

                    S_REPORT: begin
                        r_busy <= 1'b0;
                        if (r_ships == '0) begin
                            r_state     <= S_DONE;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state      <= S_READY;
                            r_shot_ready <= 1'b1;
                        end
                    end

                    S_DONE: begin
                        r_state <= S_DONE;
                    end

                    default: begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_shot_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sif.shot_ready   = r_shot_ready;
    assign sif.wr_en        = r_wr_en;
    assign sif.wr_row       = r_wr_row;
    assign sif.wr_col       = r_wr_col;
    assign sif.wr_data      = r_wr_data;
    assign sif.result_valid = r_result_valid;
    assign sif.result_code  = r_result_code;
    assign ships_left       = r_ships;
    assign game_over        = r_game_over;
    assign busy             = r_busy;

endmodule

// File: tb/tb_shot_resolver.sv
// Directed bench for shot_resolver: table of shots with hand-computed
// expectations plus hand-written scan, game-over and reset sequences.
module tb_shot_resolver;
    import batalla_pkg::*;

    localparam int N  = BOARD_N;
    localparam int CW = $clog2(N*N+1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    cell_t [N-1:0][N-1:0] board;
    logic [CW-1:0]        ships_left;
    logic                 game_over;
    logic                 busy;

    shot_resolver_if sif();

    shot_resolver #(.N(N), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .board      (board),
        .sif        (sif),
        .ships_left (ships_left),
        .game_over  (game_over),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] row;
        logic [2:0] col;
        logic       exp_wr;
        logic [1:0] exp_data;
        logic [1:0] exp_code;
        int         exp_ships;
        logic       exp_over;
    } vec_t;

    vec_t vecs[8];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic fill_board(input logic with_ships);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                board[r][c] = AGUA;
        if (with_ships) begin
            board[0][0] = BARCO;
            board[1][4] = BARCO;
            board[4][2] = BARCO;
        end
    endtask

    task automatic scan_game(input int exp_ships, input logic exp_over, input logic poke_start);
        int cnt;
        cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("scan_over_cleared", game_over, 0);
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            start = (poke_start && cnt == 10);
            @(negedge clk);
        end
        start = 1'b0;
        check("scan_cycles", cnt, 25);
        check("scan_ships", ships_left, exp_ships);
        check("scan_over", game_over, exp_over);
        check("scan_ready", sif.shot_ready, !exp_over);
        $display("scan: busy_cycles=%0d ships_left=%0d game_over=%0b", cnt, ships_left, game_over);
    endtask

    task automatic run_shot(input vec_t v);
        int   waitc;
        logic seen_wr;
        waitc = 0;
        while (sif.shot_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("ready_before_shot", sif.shot_ready, 1);
        sif.shot_valid = 1'b1;
        sif.shot_row   = v.row;
        sif.shot_col   = v.col;
        @(negedge clk);  // CHECK
        sif.shot_valid = 1'b0;
        check("check_busy", busy, 1);
        check("check_ready", sif.shot_ready, 0);
        check("check_wr_en", sif.wr_en, 0);
        @(negedge clk);  // WRITE
        seen_wr = sif.wr_en;
        check("write_wr_en", sif.wr_en, v.exp_wr);
        check("write_result_valid", sif.result_valid, 0);
        if (v.exp_wr) begin
            check("write_row", sif.wr_row, v.row);
            check("write_col", sif.wr_col, v.col);
            check("write_data", sif.wr_data, v.exp_data);
        end
        if (sif.wr_en === 1'b1 && sif.wr_row < 3'(N) && sif.wr_col < 3'(N))
            board[sif.wr_row][sif.wr_col] = sif.wr_data;
        @(negedge clk);  // REPORT
        check("report_valid", sif.result_valid, 1);
        check("report_code", sif.result_code, v.exp_code);
        check("report_wr_en", sif.wr_en, 0);
        check("report_ships", ships_left, v.exp_ships);
        $display("shot (%0d,%0d): wr_en=%0b code=%0d ships_left=%0d",
                 v.row, v.col, seen_wr, sif.result_code, ships_left);
        @(negedge clk);  // turnaround
        check("after_valid", sif.result_valid, 0);
        check("after_ready", sif.shot_ready, !v.exp_over);
        check("after_over", game_over, v.exp_over);
        check("after_busy", busy, 0);
    endtask

    initial begin
        int hits;
        // row col wr data code ships over
        vecs[0] = '{3'd2, 3'd3, 1'b1, 2'b10, 2'b00, 3, 1'b0};  // miss on water
        vecs[1] = '{3'd0, 3'd0, 1'b1, 2'b11, 2'b01, 2, 1'b0};  // hit
        vecs[2] = '{3'd0, 3'd0, 1'b0, 2'b00, 2'b10, 2, 1'b0};  // immediate re-shot
        vecs[3] = '{3'd5, 3'd1, 1'b0, 2'b00, 2'b11, 2, 1'b0};  // row off board
        vecs[4] = '{3'd2, 3'd3, 1'b0, 2'b00, 2'b10, 2, 1'b0};  // repeat of a miss
        vecs[5] = '{3'd1, 3'd7, 1'b0, 2'b00, 2'b11, 2, 1'b0};  // col off board
        vecs[6] = '{3'd1, 3'd4, 1'b1, 2'b11, 2'b01, 1, 1'b0};  // hit
        vecs[7] = '{3'd4, 3'd2, 1'b1, 2'b11, 2'b01, 0, 1'b1};  // last ship

        sif.shot_valid = 1'b0;
        sif.shot_row   = 3'd0;
        sif.shot_col   = 3'd0;
        fill_board(1'b0);

        repeat (2) @(negedge clk);
        check("reset_wr_en", sif.wr_en, 0);
        check("reset_ready", sif.shot_ready, 0);
        check("reset_result_valid", sif.result_valid, 0);
        check("reset_result_code", sif.result_code, 0);
        check("reset_wr_row", sif.wr_row, 0);
        check("reset_wr_data", sif.wr_data, 0);
        check("reset_ships", ships_left, 0);
        check("reset_over", game_over, 0);
        check("reset_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        fill_board(1'b1);
        scan_game(3, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++)
            run_shot(vecs[i]);

        // Shots are ignored once the game is over.
        hits = 0;
        sif.shot_valid = 1'b1;
        sif.shot_row   = 3'd2;
        sif.shot_col   = 3'd2;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sif.wr_en !== 1'b0 || sif.result_valid !== 1'b0 || busy !== 1'b0) hits++;
        end
        sif.shot_valid = 1'b0;
        check("done_ignores_shots", hits, 0);
        check("done_over_held", game_over, 1);
        $display("done: ignored shot activity=%0d game_over=%0b", hits, game_over);

        fill_board(1'b1);
        scan_game(3, 1'b0, 1'b0);

        // Reset asserted while a hit is in WRITE.
        sif.shot_valid = 1'b1;
        sif.shot_row   = 3'd0;
        sif.shot_col   = 3'd0;
        @(negedge clk);
        sif.shot_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_wr_en", sif.wr_en, 1);
        rst = 1'b0;
        #1;
        check("async_wr_en", sif.wr_en, 0);
        check("async_busy", busy, 0);
        check("async_ships", ships_left, 0);
        check("async_wr_data", sif.wr_data, 0);
        check("async_ready", sif.shot_ready, 0);
        $display("reset mid-write: wr_en=%0b busy=%0b ships_left=%0d", sif.wr_en, busy, ships_left);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("release_wr_en", sif.wr_en, 0);
        check("release_busy", busy, 0);
        check("release_ready", sif.shot_ready, 0);

        fill_board(1'b0);
        scan_game(0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
